// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the parametrised FIFO pointer/status controller.
package fifo_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AFULL_TH  = 14;
    localparam int DEF_AEMPTY_TH = 2;

    // Smallest w with 2**w >= value; at least 1 so that no vector collapses to zero width.
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and wraps by explicit compare, so DEPTH need not be a power of two.
module fifo_ptr_ctr
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = clog2w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;

    // Next pointer value: advance on inc, wrapping at the last entry.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (inc) begin
            if (ptr_r == LAST) begin
                ptr_nxt_s = {ADDR_W{1'b0}};
            end else begin
                ptr_nxt_s = ptr_r + ADDR_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register; the flush wins over any increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl_param.sv
// Single-clock FIFO controller: drives the address/enable pins of an external dual-port RAM
// and keeps occupancy, threshold flags and sticky overflow/underflow.
module fifo_ctrl_param
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    localparam int ADDR_W   = clog2w(DEPTH),
    localparam int CNT_W    = clog2w(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              write_en,
    input  logic              read_en,
    output logic              write_en_o,
    output logic              read_en_o,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_TH);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_s;
    logic             empty_s;
    logic             write_accept_s;
    logic             read_accept_s;
    logic             overflow_set_s;
    logic             underflow_set_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Acceptance: a write into a full FIFO only goes through alongside an accepted read.
    always_comb begin
        read_accept_s   = read_en & ~empty_s & ~clear;
        write_accept_s  = write_en & ~clear & (~full_s | read_accept_s);
        overflow_set_s  = write_en & ~write_accept_s & ~clear;
        underflow_set_s = read_en & ~read_accept_s & ~clear;
    end

    // Occupancy update; simultaneous read and write leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({write_accept_s, read_accept_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            2'b11:   count_nxt_s = count_r;
            2'b00:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear) begin
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_r | overflow_set_s;
            underflow_r <= underflow_r | underflow_set_s;
        end
    end

    fifo_ptr_ctr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (write_accept_s),
        .ptr   (wr_ptr)
    );

    fifo_ptr_ctr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (read_accept_s),
        .ptr   (rd_ptr)
    );

    assign write_en_o   = write_accept_s;
    assign read_en_o    = read_accept_s;
    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= CNT_AFULL);
    assign almost_empty = (count_r <= CNT_AEMPTY);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Directed bench for fifo_ctrl_param at DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.
module tb_fifo_ctrl_param;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       write_en;
    logic       read_en;
    logic       write_en_o;
    logic       read_en_o;
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    fifo_ctrl_param #(
        .DEPTH     (16),
        .AFULL_TH  (14),
        .AEMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .write_en     (write_en),
        .read_en      (read_en),
        .write_en_o   (write_en_o),
        .read_en_o    (read_en_o),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        clear    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: two writes, then async reset between edges while idle
        write_en = 1'b1;
        tick();
        tick();
        write_en = 1'b0;
        check("pre_reset_count", 32'(count), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 2: sixteen consecutive writes
        write_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check("fill_wr_strobe", 32'(write_en_o), 32'd1);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_aempty", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
            check("fill_afull", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
            check("fill_wr_ptr", 32'(wr_ptr), 32'(i % 16));
        end

        // 3: write into a full FIFO
        #1;
        check("ovf_wr_strobe", 32'(write_en_o), 32'd0);
        tick();
        write_en = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_wr_ptr", 32'(wr_ptr), 32'd0);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ovf_sticky", 32'(overflow), 32'd1);
        end
        clear    = 1'b1;
        write_en = 1'b1;
        read_en  = 1'b1;
        #1;
        check("clr_wr_strobe", 32'(write_en_o), 32'd0);
        check("clr_rd_strobe", 32'(read_en_o), 32'd0);
        tick();
        clear    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_underflow", 32'(underflow), 32'd0);
        check("clr_wr_ptr", 32'(wr_ptr), 32'd0);

        // 4: read from empty, then read+write while empty
        read_en = 1'b1;
        #1;
        check("udf_rd_strobe", 32'(read_en_o), 32'd0);
        tick();
        check("udf_rd_ptr", 32'(rd_ptr), 32'd0);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        write_en = 1'b1;
        #1;
        check("rw_empty_wr_strobe", 32'(write_en_o), 32'd1);
        check("rw_empty_rd_strobe", 32'(read_en_o), 32'd0);
        tick();
        write_en = 1'b0;
        read_en  = 1'b0;
        check("rw_empty_count", 32'(count), 32'd1);
        check("rw_empty_udf", 32'(underflow), 32'd1);
        check("rw_empty_wr_ptr", 32'(wr_ptr), 32'd1);
        check("rw_empty_rd_ptr", 32'(rd_ptr), 32'd0);

        // 5: full with both pointers at 5, then 20 cycles of read+write
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        write_en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        write_en = 1'b0;
        read_en  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        read_en  = 1'b0;
        write_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("lock_pre_count", 32'(count), 32'd16);
        check("lock_pre_wr_ptr", 32'(wr_ptr), 32'd5);
        check("lock_pre_rd_ptr", 32'(rd_ptr), 32'd5);
        read_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            #1;
            check("lock_wr_strobe", 32'(write_en_o), 32'd1);
            check("lock_rd_strobe", 32'(read_en_o), 32'd1);
            tick();
            check("lock_count", 32'(count), 32'd16);
            check("lock_full", 32'(full), 32'd1);
            check("lock_wr_ptr", 32'(wr_ptr), 32'((5 + k) % 16));
            check("lock_rd_ptr", 32'(rd_ptr), 32'((5 + k) % 16));
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        check("lock_overflow", 32'(overflow), 32'd0);
        check("lock_underflow", 32'(underflow), 32'd0);

        // 6: reset mid-burst at count 7
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        write_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("burst_count", 32'(count), 32'd7);
        #3;
        reset = 1'b1;
        #1;
        check("burst_rst_count", 32'(count), 32'd0);
        check("burst_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("burst_rst_empty", 32'(empty), 32'd1);
        write_en = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        write_en = 1'b1;
        #1;
        check("post_rst_wr_strobe", 32'(write_en_o), 32'd1);
        check("post_rst_wr_addr", 32'(wr_ptr), 32'd0);
        tick();
        write_en = 1'b0;
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_wr_ptr", 32'(wr_ptr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised read/write pointer and status controller for a single-clock synchronous FIFO. It is the successor to the write-only input controller. It manages both pointers, occupancy, full/empty and programmable almost-flags, sticky overflow/underflow, and a synchronous flush. It drives the address and enable pins of an external dual-port RAM; it does not store data itself.

Parameters:
DEPTH, 16, number of FIFO entries; any integer >= 2 (power of two not required)
AFULL_TH, 14, almost_full asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
(localparam) ADDR_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush, active-high
write_en  in  1  write request
read_en  in  1  read request
write_en_o  out  1  RAM write strobe (request accepted)
read_en_o  out  1  RAM read strobe (request accepted)
wr_ptr  out  ADDR_W  RAM write address for this cycle
rd_ptr  out  ADDR_W  RAM read address for this cycle
count  out  CNT_W  current occupancy, 0..DEPTH
full, empty  out  1  count==DEPTH / count==0
almost_full, almost_empty  out  1  threshold flags
overflow, underflow  out  1  sticky error flags

Behaviour:
- Reset (async, immediate, regardless of clk): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Consequently empty=1, almost_empty=1, full=0, almost_full=0.
- State registers: wr_ptr, rd_ptr, count, overflow, underflow. full, empty, almost_full and almost_empty are pure decodes of registered count, with no combinational path from inputs.
- Acceptance (combinational, same cycle):
  - read_en_o = read_en & ~empty & ~clear.
  - write_en_o = write_en & ~clear & (~full | read_en_o). A write into a full FIFO is accepted only together with an accepted read.
- The RAM writes mem[wr_ptr] on the edge where write_en_o=1. RAM read data for rd_ptr is the RAM's concern (latency is external).
- On each rising edge when not clear:
  - wr_ptr advances by 1 if write_en_o.
  - rd_ptr advances by 1 if read_en_o.
  - A pointer at DEPTH-1 wraps to 0 (explicit compare, not modulo 2^ADDR_W).
  - count: +1 if write only; -1 if read only; unchanged if both or neither. It never exceeds DEPTH and never goes below 0.
- Errors:
  - overflow sets on the edge where write_en=1 and write_en_o=0 while clear=0.
  - underflow sets on the edge where read_en=1 and read_en_o=0 while clear=0.
  - Both are sticky until reset or clear. Rejected requests do not change pointers or count.
- clear: on the edge, pointers and count go to 0 and both error flags go to 0. Both strobes are forced 0 during the clear cycle. clear takes priority over all requests.
- Simultaneous read+write while empty: the read is rejected (underflow sets), the write is accepted, and count becomes 1.
- Simultaneous read+write while full: both are accepted, count stays DEPTH, and both pointers advance.
- reset asserted mid-burst: state goes to reset values immediately. The first accepted write after deassertion targets address 0.

Decomposition:
- Package fifo_pkg holds:
  - default DEPTH, AFULL_TH and AEMPTY_TH constants;
  - a clog2-style width function for ADDR_W and CNT_W.
- Sub-module fifo_ptr_ctr (parameter DEPTH; ports clk, reset, clear, inc, ptr) implements the wrapping pointer. It is instantiated twice, once for write and once for read.
- Count, flag decode and error logic remain in the top.

Test Plan:
1. Assert reset asynchronously between edges during idle -> outputs immediately show ptrs 0, count 0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
2. DEPTH=16: issue 16 consecutive writes -> almost_empty drops after the 3rd edge (count=3); almost_full rises at count=14; full=1 after the 16th edge; wr_ptr wraps to 0.
3. With the FIFO full, issue a 17th write with no read -> write_en_o=0, count stays 16, overflow=1 and remains 1 over 5 idle cycles; then pulse clear -> count=0, empty=1, overflow=0.
4. With the FIFO empty, read_en=1 -> read_en_o=0, rd_ptr stays 0, underflow=1. Then write+read in the same cycle -> write accepted, count=1, underflow still 1.
5. With the FIFO full (wr_ptr=rd_ptr=5 after wrap), hold write+read for 20 cycles -> count stays 16, full stays 1, both ptrs wrap 15->0 in lockstep, no overflow.
6. Assert reset mid-burst (count=7) -> count=0 instantly. After release, one write -> write_en_o=1 with wr_ptr=0; count=1 after the edge.
